id_ex_stage: RTL

//   ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the 5-stage CPU.

---
 rtl/id_ex_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from MEM/WB and load-use stall detection.
// Captures decoded fields from ID every cycle. A flush or a load-use stall turns the
// captured entry into a bubble. The ALU operands are resolved combinationally from the
// registered sources.
module id_ex_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RADDR   = 5,
    parameter logic [3:0]  ALU_NOP = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_use_rt,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [3:0]       id_aluop,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             flush,
    input  logic             mem_regwrite,
    input  logic [RADDR-1:0] mem_rd,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_regwrite,
    input  logic [RADDR-1:0] wb_rd,
    input  logic [WIDTH-1:0] wb_result,
    output logic             stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic [4:0]       alu_shamt,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite
);

    logic             ex_valid_q, ex_valid_d;
    logic [RADDR-1:0] ex_rs_q, ex_rs_d;
    logic [RADDR-1:0] ex_rt_q, ex_rt_d;
    logic [RADDR-1:0] ex_rd_q, ex_rd_d;
    logic [WIDTH-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [WIDTH-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]       ex_shamt_q, ex_shamt_d;
    logic [3:0]       ex_aluop_q, ex_aluop_d;
    logic             ex_alusrc_q, ex_alusrc_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memread_q, ex_memread_d;
    logic             ex_memwrite_q, ex_memwrite_d;

    logic [WIDTH-1:0] fwd_rs, fwd_rt;

    // Load-use hazard: the load in EX produces its value too late for the instruction in ID.
    always_comb begin
        logic rs_hit, rt_hit;
        rs_hit = (ex_rd_q == id_rs);
        rt_hit = id_use_rt && (ex_rd_q == id_rt);
        stall  = id_valid && ex_valid_q && ex_memread_q && (ex_rd_q != '0) && (rs_hit || rt_hit);
    end

    // Next EX contents: bubble on flush/stall (flush wins, stall stays visible upstream).
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rs_d       = ex_rs_q;
        ex_rt_d       = ex_rt_q;
        ex_rd_d       = ex_rd_q;
        ex_rs_data_d  = ex_rs_data_q;
        ex_rt_data_d  = ex_rt_data_q;
        ex_imm_d      = ex_imm_q;
        ex_shamt_d    = ex_shamt_q;
        ex_aluop_d    = ex_aluop_q;
        ex_alusrc_d   = ex_alusrc_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        ex_memwrite_d = ex_memwrite_q;
        if (flush || stall) begin
            // Operand fields keep stale values; nothing downstream acts on them without ex_valid.
            ex_valid_d    = 1'b0;
            ex_rd_d       = '0;
            ex_aluop_d    = ALU_NOP;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            ex_memwrite_d = 1'b0;
        end else begin
            ex_valid_d    = id_valid;
            ex_rs_d       = id_rs;
            ex_rt_d       = id_rt;
            ex_rd_d       = id_rd;
            ex_rs_data_d  = id_rs_data;
            ex_rt_data_d  = id_rt_data;
            ex_imm_d      = id_imm;
            ex_shamt_d    = id_shamt;
            ex_aluop_d    = id_aluop;
            ex_alusrc_d   = id_alusrc;
            ex_regwrite_d = id_valid && id_regwrite;
            ex_memread_d  = id_valid && id_memread;
            ex_memwrite_d = id_valid && id_memwrite;
        end
    end

    // EX pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_rs_data_q  <= '0;
            ex_rt_data_q  <= '0;
            ex_imm_q      <= '0;
            ex_shamt_q    <= '0;
            ex_aluop_q    <= ALU_NOP;
            ex_alusrc_q   <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs_data_q  <= ex_rs_data_d;
            ex_rt_data_q  <= ex_rt_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_shamt_q    <= ex_shamt_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_alusrc_q   <= ex_alusrc_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
        end
    end

    // Operand forwarding: MEM is younger than WB so it wins; $0 is never forwarded.
    always_comb begin
        if (mem_regwrite && (mem_rd == ex_rs_q) && (ex_rs_q != '0)) begin
            fwd_rs = mem_result;
        end else if (wb_regwrite && (wb_rd == ex_rs_q) && (ex_rs_q != '0)) begin
            fwd_rs = wb_result;
        end else begin
            fwd_rs = ex_rs_data_q;
        end
        if (mem_regwrite && (mem_rd == ex_rt_q) && (ex_rt_q != '0)) begin
            fwd_rt = mem_result;
        end else if (wb_regwrite && (wb_rd == ex_rt_q) && (ex_rt_q != '0)) begin
            fwd_rt = wb_result;
        end else begin
            fwd_rt = ex_rt_data_q;
        end
    end

    // EX-stage outputs.
    always_comb begin
        ex_valid      = ex_valid_q;
        alu_a         = fwd_rs;
        alu_b         = ex_alusrc_q ? ex_imm_q : fwd_rt;
        alu_op        = ex_aluop_q;
        alu_shamt     = ex_shamt_q;
        ex_store_data = fwd_rt;
        ex_rd         = ex_rd_q;
        ex_regwrite   = ex_regwrite_q;
        ex_memread    = ex_memread_q;
        ex_memwrite   = ex_memwrite_q;
    end

endmodule
